// File: rtl/util_cpack_ts_stream_if.sv
// Sample-stream bus for util_cpack_ts_stream.
//   in_valid / in_data   : one beat of NUM_OF_CHANNELS samples
//   in_overflow          : pulse when a beat's words could not be stored
//   out_valid / out_ready: output handshake, transfer when both high
//   out_data / out_sync  : packed output word and its sync qualifier
// master = stream source / sink side, slave = packer side.
interface util_cpack_ts_stream_if #(
    parameter int unsigned NUM_OF_CHANNELS = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned OUT_WIDTH       = 64
);
    logic                                    in_valid;
    logic [NUM_OF_CHANNELS*SAMPLE_WIDTH-1:0] in_data;
    logic                                    in_overflow;
    logic                                    out_valid;
    logic                                    out_ready;
    logic [OUT_WIDTH-1:0]                    out_data;
    logic                                    out_sync;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_overflow, out_valid, out_data, out_sync
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_overflow, out_valid, out_data, out_sync
    );
endinterface

// File: rtl/util_cpack_ts_stream.sv
// Channel packer with timestamp headers.
// Enabled channel samples of each beat are compacted into OUT_WIDTH words,
// lane 0 in the low bits. A zero-extended timestamp header word is inserted
// before data words at block boundaries. Words go through a small FIFO; a
// beat whose words do not fit is dropped as a whole.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   enable          : channel enable mask (registered; a change flushes)
//   timestamp       : free-running 64-bit time
//   timestamp_every : data words per header block, 0 = no headers
//   bus (slave)     : in_valid/in_data/in_overflow, out_valid/out_ready/
//                     out_data/out_sync
//   drop_count      : dropped word counter, present only when the macro
//                     UTIL_CPACK_TS_DROP_COUNT_EN is defined
module util_cpack_ts_stream #(
    parameter int unsigned NUM_OF_CHANNELS = 4,
    parameter int unsigned SAMPLE_WIDTH    = 16,
    parameter int unsigned OUT_WIDTH       = 64,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_OF_CHANNELS-1:0] enable,
    input  logic [63:0]                timestamp,
    input  logic [31:0]                timestamp_every,
`ifdef UTIL_CPACK_TS_DROP_COUNT_EN
    output logic [31:0]                drop_count,
`endif
    util_cpack_ts_stream_if.slave      bus
);
    localparam int unsigned NW    = NUM_OF_CHANNELS * SAMPLE_WIDTH;
    localparam int unsigned LANES = OUT_WIDTH / SAMPLE_WIDTH;
    localparam int unsigned PW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW    = AW + 1;
    localparam int          LANES_I = int'(LANES);
    localparam int          SW_I    = int'(SAMPLE_WIDTH);
    localparam int          NCH_I   = int'(NUM_OF_CHANNELS);

    // Input stage: beat, mask and timestamp registered together
    logic [NUM_OF_CHANNELS-1:0] mask_q, mask_prev;
    logic                       v_q;
    logic [NW-1:0]              d_q;
    logic [63:0]                ts_q;

    // Packing state
    logic [PW-1:0]        fill_ptr;
    logic [OUT_WIDTH-1:0] partial;
    logic [63:0]          ts_word;
    logic                 aligned;
    logic [31:0]          blk_cnt;
    logic                 force_hdr;

    // FIFO
    logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic                 mem_sync [FIFO_DEPTH];
    logic [CW-1:0]        wr_ptr, rd_ptr;
    logic                 out_valid_q, out_sync_q, overflow_q;
    logic [OUT_WIDTH-1:0] out_data_q;

    // Combinational packing / FIFO control
    logic                 flush, beat, complete, hdr_en, need_hdr;
    logic [PW-1:0]        fp0, fp_nx;
    logic [OUT_WIDTH-1:0] part0, cur, carry, fw_data, head_data;
    logic [31:0]          bc0, bc_nx;
    logic                 force0, force_nx, aligned_nx, word_aligned, dsync;
    logic                 fw_sync, head_sync;
    logic [NW-1:0]        comp;
    int                   cnt, fp_i, sum;
    logic [63:0]          word_ts;
    logic [CW-1:0]        n_words, count, free, count_nx, rd_nx;
    logic                 pop, wr_ok, drop;

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_sync    = out_sync_q;
    assign bus.in_overflow = overflow_q;

    // Beat capture; mask_prev lags mask_q so a mask change is seen for one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q    <= '0;
            mask_prev <= '0;
            v_q       <= 1'b0;
            d_q       <= '0;
            ts_q      <= '0;
        end else begin
            mask_prev <= mask_q;
            mask_q    <= enable;
            v_q       <= bus.in_valid;
            d_q       <= bus.in_data;
            ts_q      <= timestamp;
        end
    end

    // Packing datapath: flush first, then place the beat with the new mask
    always_comb begin
        flush  = (mask_q != mask_prev);
        fp0    = flush ? '0 : fill_ptr;
        part0  = flush ? '0 : partial;
        bc0    = flush ? '0 : blk_cnt;
        force0 = force_hdr | flush;

        comp = '0;
        cnt  = 0;
        for (int c = 0; c < NCH_I; c++) begin
            if (mask_q[c]) begin
                comp[cnt*SW_I +: SAMPLE_WIDTH] = d_q[c*SW_I +: SAMPLE_WIDTH];
                cnt = cnt + 1;
            end
        end
        beat = v_q && (cnt != 0);

        // Samples land at fp0..; those past the last lane start the next word
        fp_i  = int'(32'(fp0));
        cur   = part0;
        carry = '0;
        for (int l = 0; l < LANES_I; l++) begin
            if (l >= fp_i && (l - fp_i) < cnt)
                cur[l*SW_I +: SAMPLE_WIDTH] = comp[(l - fp_i)*SW_I +: SAMPLE_WIDTH];
            if ((l + LANES_I - fp_i) < cnt)
                carry[l*SW_I +: SAMPLE_WIDTH] = comp[(l + LANES_I - fp_i)*SW_I +: SAMPLE_WIDTH];
        end
        sum      = fp_i + cnt;
        complete = beat && (sum >= LANES_I);
        fp_nx    = fp0;
        if (beat)
            fp_nx = complete ? PW'(sum - LANES_I) : PW'(sum);

        // A word starting at lane 0 of this beat takes this beat's timestamp
        word_ts      = (fp0 == '0) ? ts_q : ts_word;
        word_aligned = (fp0 == '0) | aligned;
        aligned_nx   = beat ? (complete ? 1'b0 : word_aligned) : aligned;

        hdr_en   = (timestamp_every != 32'd0);
        need_hdr = hdr_en && ((bc0 == 32'd0) || force0);
        dsync    = !hdr_en && word_aligned;
        n_words  = need_hdr ? CW'(2) : CW'(1);

        // Free entries include a pop happening in the same cycle
        pop   = out_valid_q && bus.out_ready;
        count = wr_ptr - rd_ptr;
        free  = CW'(FIFO_DEPTH) - count + CW'(pop);
        wr_ok = complete && (free >= n_words);
        drop  = complete && !wr_ok;

        bc_nx = bc0;
        if (!hdr_en)
            bc_nx = 32'd0;
        else if (wr_ok)
            bc_nx = (bc0 >= timestamp_every - 32'd1) ? 32'd0 : bc0 + 32'd1;

        force_nx = force0;
        if (drop)
            force_nx = 1'b1;
        else if (wr_ok && need_hdr)
            force_nx = 1'b0;

        fw_data = need_hdr ? OUT_WIDTH'(word_ts) : cur;
        fw_sync = need_hdr ? 1'b1 : dsync;

        // Next head of FIFO; bypass when the head slot is written this cycle
        rd_nx    = rd_ptr + CW'(pop);
        count_nx = count + (wr_ok ? n_words : '0) - CW'(pop);
        if (wr_ok && (rd_nx == wr_ptr)) begin
            head_data = fw_data;
            head_sync = fw_sync;
        end else begin
            head_data = mem_data[rd_nx[AW-1:0]];
            head_sync = mem_sync[rd_nx[AW-1:0]];
        end
    end

    // Packing state update
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_ptr  <= '0;
            partial   <= '0;
            ts_word   <= '0;
            aligned   <= 1'b0;
            blk_cnt   <= '0;
            force_hdr <= 1'b1;
        end else begin
            fill_ptr  <= fp_nx;
            partial   <= beat ? (complete ? carry : cur) : part0;
            aligned   <= aligned_nx;
            blk_cnt   <= bc_nx;
            force_hdr <= force_nx;
            if (beat && ((fp0 == '0) || (sum > LANES_I)))
                ts_word <= ts_q;
        end
    end

    // FIFO storage, no reset needed on the array
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            if (need_hdr) begin
                mem_data[wr_ptr[AW-1:0]]             <= OUT_WIDTH'(word_ts);
                mem_sync[wr_ptr[AW-1:0]]             <= 1'b1;
                mem_data[AW'(wr_ptr[AW-1:0] + 1'b1)] <= cur;
                mem_sync[AW'(wr_ptr[AW-1:0] + 1'b1)] <= 1'b0;
            end else begin
                mem_data[wr_ptr[AW-1:0]] <= cur;
                mem_sync[wr_ptr[AW-1:0]] <= dsync;
            end
        end
    end

    // FIFO pointers and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sync_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + n_words;
            rd_ptr      <= rd_nx;
            out_valid_q <= (count_nx != '0);
            out_data_q  <= head_data;
            out_sync_q  <= head_sync;
            overflow_q  <= drop;
        end
    end

`ifdef UTIL_CPACK_TS_DROP_COUNT_EN
    // Saturating count of dropped words
    always_ff @(posedge clk) begin
        if (reset)
            drop_count <= '0;
        else if (drop) begin
            if (drop_count > (32'hFFFF_FFFF - 32'(n_words)))
                drop_count <= 32'hFFFF_FFFF;
            else
                drop_count <= drop_count + 32'(n_words);
        end
    end
`endif

endmodule

// File: tb/tb_util_cpack_ts_stream.sv
// Bench for util_cpack_ts_stream: directed scenarios plus random beats,
// checked against a sample-queue reference model.
module tb_util_cpack_ts_stream;
    localparam int unsigned N     = 4;
    localparam int unsigned SW    = 16;
    localparam int unsigned OW    = 64;
    localparam int unsigned FD    = 4;
    localparam int unsigned LANES = OW / SW;

    typedef struct packed {
        logic          sync;
        logic [OW-1:0] data;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  enable;
    logic [63:0]   timestamp;
    logic [31:0]   every;
`ifdef UTIL_CPACK_TS_DROP_COUNT_EN
    logic [31:0]   drop_count;
`endif

    util_cpack_ts_stream_if #(.NUM_OF_CHANNELS(N), .SAMPLE_WIDTH(SW), .OUT_WIDTH(OW)) bus ();

    util_cpack_ts_stream #(
        .NUM_OF_CHANNELS(N), .SAMPLE_WIDTH(SW), .OUT_WIDTH(OW), .FIFO_DEPTH(FD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .timestamp       (timestamp),
        .timestamp_every (every),
`ifdef UTIL_CPACK_TS_DROP_COUNT_EN
        .drop_count      (drop_count),
`endif
        .bus             (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) timestamp <= 64'h0123_4567_89AB_0000;
        else       timestamp <= timestamp + 64'd1;
    end

    int checks   = 0;
    int failures = 0;

    // Reference model state
    word_t         exp_q [$];
    logic [SW-1:0] m_cur [$];
    logic [63:0]   m_ts;
    bit            m_aligned;
    int unsigned   m_bc;
    bit            m_force;
    logic [N-1:0]  m_mask;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_flush();
        m_cur.delete();
        m_bc    = 0;
        m_force = 1'b1;
    endfunction

    // One beat: append enabled samples; each full word goes out with an optional header
    task automatic m_beat(input logic [N-1:0] m, input logic [N*SW-1:0] d,
                          input logic [63:0] ts, input logic [31:0] ev, input bit drop);
        bit first;
        first = 1'b1;
        for (int c = 0; c < int'(N); c++) begin
            if (m[c]) begin
                if (m_cur.size() == 0) begin
                    m_ts      = ts;
                    m_aligned = first;
                end
                m_cur.push_back(d[c*SW +: SW]);
                first = 1'b0;
                if (m_cur.size() == int'(LANES)) begin
                    logic [OW-1:0] w;
                    bit            hdr;
                    w = '0;
                    for (int l = 0; l < int'(LANES); l++) w[l*SW +: SW] = m_cur[l];
                    hdr = (ev != 0) && (m_bc == 0 || m_force);
                    if (!drop) begin
                        if (hdr) exp_q.push_back({1'b1, OW'(m_ts)});
                        exp_q.push_back({(ev == 0) && m_aligned, w});
                        if (ev == 0)               m_bc = 0;
                        else if (m_bc >= ev - 1)   m_bc = 0;
                        else                       m_bc = m_bc + 1;
                        if (hdr) m_force = 1'b0;
                    end else begin
                        m_force = 1'b1;
                    end
                    m_cur.delete();
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_mask(input logic [N-1:0] m);
        if (m !== m_mask) begin
            m_flush();
            m_mask = m;
        end
        enable = m;
    endtask

    task automatic beat(input logic [N-1:0] m, input logic [N*SW-1:0] d, input bit drop);
        set_mask(m);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        m_beat(m, d, timestamp, every, drop);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [N*SW-1:0] rnd_data();
        return {$urandom(), $urandom()};
    endfunction

    // Output scoreboard
    always @(negedge clk) begin
        word_t e;
        if (!reset && bus.out_valid && bus.out_ready) begin
            chk("exp_available", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 128'(bus.out_data), 128'(e.data));
                chk("out_sync", 128'(bus.out_sync), 128'(e.sync));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        logic [OW-1:0] hold;
        logic [N-1:0]  m;
        logic [31:0]   ev_tab [3];

        reset        = 1'b1;
        enable       = '0;
        every        = 32'd0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        m_mask       = '0;
        m_flush();
        idle(3);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_out_sync", 128'(bus.out_sync), 128'd0);
        chk("rst_out_data", 128'(bus.out_data), 128'd0);
        chk("rst_in_overflow", 128'(bus.in_overflow), 128'd0);
`ifdef UTIL_CPACK_TS_DROP_COUNT_EN
        chk("rst_drop_count", 128'(drop_count), 128'd0);
`endif
        reset = 1'b0;
        idle(2);

        // Headers every 2 data words, full mask; first-word latency
        every = 32'd2;
        beat(4'hF, rnd_data(), 1'b0);
        chk("latency_early", 128'(bus.out_valid), 128'd0);
        idle(1);
        chk("latency_valid", 128'(bus.out_valid), 128'd1);
        for (int i = 0; i < 4; i++) beat(4'hF, rnd_data(), 1'b0);
        idle(8);

        // Headers off, three channels: four beats make three words
        every = 32'd0;
        idle(2);
        for (int i = 0; i < 4; i++) beat(4'h7, rnd_data(), 1'b0);
        idle(6);

        // Single channel: four beats make one word
        for (int i = 0; i < 4; i++) beat(4'h1, rnd_data(), 1'b0);
        idle(6);

        // Mask change mid-word discards the partial word
        every = 32'd2;
        idle(2);
        beat(4'h7, rnd_data(), 1'b0);
        beat(4'h3, rnd_data(), 1'b0);
        beat(4'h3, rnd_data(), 1'b0);
        idle(6);

        // Back-pressure: third beat cannot fit and is dropped whole
        every = 32'd1;
        set_mask(4'hF);
        idle(4);
        bus.out_ready = 1'b0;
        beat(4'hF, rnd_data(), 1'b0);
        beat(4'hF, rnd_data(), 1'b0);
        beat(4'hF, rnd_data(), 1'b1);
        chk("ovf_before", 128'(bus.in_overflow), 128'd0);
        hold = bus.out_data;
        idle(1);
        chk("ovf_pulse", 128'(bus.in_overflow), 128'd1);
        chk("stall_hold_data", 128'(bus.out_data), 128'(hold));
        chk("stall_hold_valid", 128'(bus.out_valid), 128'd1);
        idle(1);
        chk("ovf_after", 128'(bus.in_overflow), 128'd0);
`ifdef UTIL_CPACK_TS_DROP_COUNT_EN
        chk("drop_count", 128'(drop_count), 128'd2);
`endif
        bus.out_ready = 1'b1;
        idle(6);
        beat(4'hF, rnd_data(), 1'b0);
        idle(6);

        // Reset while output pending and a beat is presented
        bus.out_ready = 1'b0;
        beat(4'hF, rnd_data(), 1'b0);
        idle(3);
        chk("pre_rst_valid", 128'(bus.out_valid), 128'd1);
        reset        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = rnd_data();
        idle(1);
        chk("rst_win_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_win_ovf", 128'(bus.in_overflow), 128'd0);
        chk("rst_win_sync", 128'(bus.out_sync), 128'd0);
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        m_flush();
        m_mask = '0;
        idle(4);
        chk("post_rst_empty", 128'(bus.out_valid), 128'd0);
        chk("post_rst_ovf", 128'(bus.in_overflow), 128'd0);
        bus.out_ready = 1'b1;

        // Random beats, spaced so the FIFO never fills
        ev_tab[0] = 32'd0;
        ev_tab[1] = 32'd1;
        ev_tab[2] = 32'd3;
        m = 4'hF;
        for (int s = 0; s < 3; s++) begin
            every = ev_tab[s];
            idle(3);
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 7) == 0) m = N'($urandom_range(0, 15));
                beat(m, rnd_data(), 1'b0);
                idle(int'($urandom_range(1, 2)));
            end
            idle(6);
        end

        idle(10);
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
